rx_sample_ctrl: RTL

Receive-side bit-timing controller for the RFID reader front end. Takes the already two-flop-synchronised receive line, tracks its transitions, and schedules one mid-bit sample strobe per bit period, replacing the free-running strobe with an edge-aligned one. It sits between the input synchroniser and the bit decoder. It provides acquisition, lock tracking and loss-of-signal timeout.

---
 rtl/rx_sample_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rx_sample_ctrl.sv
// Receive bit-timing controller: tracks rx_in transitions and issues one mid-bit sample strobe per bit.
// Optional 3-sample majority glitch filter on rx_in, enabled by defining RX_SAMPLE_CTRL_GLITCH_FILTER_EN.
module rx_sample_ctrl #(
  parameter int DIV_W      = 8,
  parameter int LOCK_EDGES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  input  logic             rx_in,
  output logic             smp_dat,
  output logic             smp_vld,
  output logic             locked,
  output logic             lost
);
  typedef enum logic [1:0] {IDLE, HUNT, ACQ, LOCKED} state_t;

  localparam logic [DIV_W-1:0] MIN_PER = DIV_W'(4);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_EDGES);
  localparam logic [7:0]       TMO     = 8'(TIMEOUT);

  logic rx_f;

`ifdef RX_SAMPLE_CTRL_GLITCH_FILTER_EN
  logic [1:0] win_q, win_d;
  logic       filt_q, filt_d;

  always_comb begin
    win_d  = {win_q[0], rx_in};
    filt_d = (rx_in & win_q[0]) | (rx_in & win_q[1]) | (win_q[0] & win_q[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      filt_q <= filt_d;
    end
  end

  assign rx_f = filt_q;
`else
  assign rx_f = rx_in;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       good_q, good_d;
  logic [7:0]       idle_q, idle_d;
  logic             rx_d_q, rx_d_d;
  logic             smp_dat_q, smp_dat_d;
  logic             smp_vld_q, smp_vld_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;

  logic [DIV_W-1:0] half, last, cnt_inc, cnt_skip;
  logic             edge_det, strobe, on_time;

  always_comb begin
    half     = period_q >> 1;
    last     = period_q - DIV_W'(1);
    edge_det = rx_f ^ rx_d_q;
    strobe   = (state_q == ACQ || state_q == LOCKED) && (cnt_q == half);
    cnt_inc  = (cnt_q == last) ? '0 : cnt_q + DIV_W'(1);
    cnt_skip = (cnt_q == period_q - DIV_W'(2)) ? '0 : cnt_q + DIV_W'(2);
    on_time  = (cnt_q == last) || (cnt_q <= DIV_W'(1));

    state_d   = state_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    good_d    = good_q;
    idle_d    = idle_q;
    rx_d_d    = rx_f;
    smp_dat_d = smp_dat_q;
    smp_vld_d = 1'b0;
    lost_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = HUNT;
          period_d = (period < MIN_PER) ? MIN_PER : period;
        end
      end
      HUNT: begin
        if (edge_det) begin
          state_d = ACQ;
          cnt_d   = '0;
          good_d  = '0;
        end
      end
      default: begin
        if (strobe) idle_d = idle_q + 8'd1;
        if (strobe && state_q == LOCKED) begin
          smp_vld_d = 1'b1;
          smp_dat_d = rx_f;
        end
        if (edge_det) begin
          idle_d = '0;
          if (state_q == ACQ) begin
            cnt_d = '0;
            if (on_time) begin
              good_d = good_q + 4'd1;
              if (good_d == LOCK_N) state_d = LOCKED;
            end else begin
              good_d = '0;
            end
          // Locked: nudge phase one cycle toward the edge instead of snapping
          end else if (cnt_q == last || cnt_q == '0) begin
            cnt_d = cnt_inc;
          end else if (cnt_q < half) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_skip;
          end
        end else if (idle_q == TMO) begin
          state_d = HUNT;
          cnt_d   = '0;
          good_d  = '0;
          idle_d  = '0;
          lost_d  = (state_q == LOCKED);
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase

    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      good_d    = '0;
      idle_d    = '0;
      smp_vld_d = 1'b0;
      lost_d    = 1'b0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= MIN_PER;
      cnt_q     <= '0;
      good_q    <= '0;
      idle_q    <= '0;
      rx_d_q    <= 1'b0;
      smp_dat_q <= 1'b0;
      smp_vld_q <= 1'b0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      idle_q    <= idle_d;
      rx_d_q    <= rx_d_d;
      smp_dat_q <= smp_dat_d;
      smp_vld_q <= smp_vld_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
    end
  end

  assign smp_dat = smp_dat_q;
  assign smp_vld = smp_vld_q;
  assign locked  = locked_q;
  assign lost    = lost_q;

endmodule
